plic: RTL and testbench

- Platform-level interrupt controller slave on the SoC memory bus, downstream of the address decoder alongside uart, clint and avl.
- Collects level-sensitive interrupt lines from peripherals and arbitrates them by priority.
- Implements claim/complete handshake registers and drives the machine external interrupt (meip) into the cpu.
- Receives offset addresses; the decoder has already subtracted the base.

---
 rtl/plic.sv | 175 +++++++++++++++++
 tb/tb_plic.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic.sv
// Platform-level interrupt controller: per-source level gateways, priority
// arbitration, claim/complete registers and a registered meip output.
module plic #(
  parameter int sources   = 8,
  parameter int prio_bits = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               plic_valid,
  input  logic               plic_instr,
  input  logic [31:0]        plic_addr,
  input  logic [31:0]        plic_wdata,
  input  logic [3:0]         plic_wstrb,
  output logic [31:0]        plic_rdata,
  output logic               plic_ready,
  input  logic [sources-1:0] plic_irq,
  output logic               plic_meip
);

  // Word offsets (byte offset >> 2) of the non-priority registers.
  localparam logic [29:0] WORD_PENDING   = 30'h020;
  localparam logic [29:0] WORD_ENABLE    = 30'h040;
  localparam logic [29:0] WORD_THRESHOLD = 30'h080;
  localparam logic [29:0] WORD_CLAIM     = 30'h081;

  typedef logic [prio_bits-1:0] prio_t;

  prio_t              prio_q [sources];
  prio_t              prio_d [sources];
  logic [sources-1:0] enable_q, enable_d;
  logic [sources-1:0] pending_q, pending_d;
  logic [sources-1:0] inflight_q, inflight_d;
  prio_t              threshold_q, threshold_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               meip_q, meip_d;

  logic [4:0]         best_id;
  prio_t              best_prio;
  logic [sources-1:0] best_oh;

  logic [29:0]        word;
  logic [4:0]         prio_idx;
  logic               prio_sel;
  logic               is_write;
  logic [4:0]         cpl_id;

  // Fetch flag, sub-word address bits and the reserved source are don't-cares.
  logic               unused_inputs;
  assign unused_inputs = ^{plic_instr, plic_addr[1:0], plic_irq[0]};

  assign word     = plic_addr[31:2];
  assign prio_idx = plic_addr[6:2];
  assign prio_sel = (plic_addr[31:7] == '0);
  assign is_write = |plic_wstrb;
  assign cpl_id   = plic_wdata[4:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strobe);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Ascending scan with strict '>' keeps the lowest id on a priority tie;
  // starting from zero also excludes priority-0 sources.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    best_oh   = '0;
    for (int i = 1; i < sources; i++) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
        best_id    = 5'(i);
        best_prio  = prio_q[i];
        best_oh    = '0;
        best_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    prio_d      = prio_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    pending_d   = pending_q;
    inflight_d  = inflight_q;
    rdata_d     = '0;
    ready_d     = plic_valid;
    meip_d      = (best_id != '0) && (best_prio > threshold_q);

    for (int i = 1; i < sources; i++) begin
      if (plic_irq[i] && !pending_q[i] && !inflight_q[i]) pending_d[i] = 1'b1;
    end

    if (plic_valid) begin
      if (prio_sel) begin
        for (int i = 1; i < sources; i++) begin
          if (prio_idx == 5'(i)) begin
            if (is_write) prio_d[i] = prio_bits'(merge_bytes(32'(prio_q[i]), plic_wdata, plic_wstrb));
            else          rdata_d   = 32'(prio_q[i]);
          end
        end
      end else begin
        case (word)
          WORD_PENDING: begin
            if (!is_write) rdata_d = 32'(pending_q);
          end
          WORD_ENABLE: begin
            if (is_write) begin
              enable_d    = sources'(merge_bytes(32'(enable_q), plic_wdata, plic_wstrb));
              enable_d[0] = 1'b0;
            end else begin
              rdata_d = 32'(enable_q);
            end
          end
          WORD_THRESHOLD: begin
            if (is_write) threshold_d = prio_bits'(merge_bytes(32'(threshold_q), plic_wdata, plic_wstrb));
            else          rdata_d     = 32'(threshold_q);
          end
          WORD_CLAIM: begin
            if (is_write) begin
              if (plic_wstrb[0]) begin
                for (int i = 1; i < sources; i++) begin
                  if (cpl_id == 5'(i)) inflight_d[i] = 1'b0;
                end
              end
            end else begin
              // Claim overrides a same-cycle gateway set: the source goes inflight.
              rdata_d    = 32'(best_id);
              pending_d  = pending_d & ~best_oh;
              inflight_d = inflight_d | best_oh;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the priority array is a handful of flops, not a RAM, so it is reset
  // along with the rest of the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < sources; i++) prio_q[i] <= '0;
      enable_q    <= '0;
      pending_q   <= '0;
      inflight_q  <= '0;
      threshold_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      meip_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      prio_q      <= prio_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      inflight_q  <= inflight_d;
      threshold_q <= threshold_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      meip_q      <= meip_d;
    end
  end

  assign plic_rdata = rdata_q;
  assign plic_ready = ready_q;
  assign plic_meip  = meip_q;

endmodule

// File: tb/tb_plic.sv
// Self-checking bench for plic: directed scenarios plus random traffic, all
// compared every cycle against a register-level reference model.
module tb_plic;
  localparam int S  = 8;
  localparam int PB = 3;
  localparam logic [31:0] SRC_MASK  = 32'((64'd1 << S) - 64'd1);
  localparam logic [31:0] PRIO_MASK = (32'd1 << PB) - 32'd1;

  logic          clock      = 1'b0;
  logic          reset      = 1'b0;
  logic          plic_valid = 1'b0;
  logic          plic_instr = 1'b0;
  logic [31:0]   plic_addr  = '0;
  logic [31:0]   plic_wdata = '0;
  logic [3:0]    plic_wstrb = '0;
  logic [S-1:0]  plic_irq   = '0;
  logic [31:0]   plic_rdata;
  logic          plic_ready;
  logic          plic_meip;

  int checks = 0;
  int errors = 0;

  plic #(.sources(S), .prio_bits(PB)) dut (
    .clock      (clock),
    .reset      (reset),
    .plic_valid (plic_valid),
    .plic_instr (plic_instr),
    .plic_addr  (plic_addr),
    .plic_wdata (plic_wdata),
    .plic_wstrb (plic_wstrb),
    .plic_rdata (plic_rdata),
    .plic_ready (plic_ready),
    .plic_irq   (plic_irq),
    .plic_meip  (plic_meip)
  );

  always #5 clock = ~clock;

  // Reference model: plain register contents, updated once per clock edge.
  int unsigned m_prio [S];
  logic [31:0] m_en, m_pend, m_infl, m_thr, m_rdata;
  logic        m_ready, m_meip;

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_prio[i] = 0;
    m_en = 0; m_pend = 0; m_infl = 0; m_thr = 0;
    m_rdata = 0; m_ready = 0; m_meip = 0;
  endtask

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] st);
    logic [31:0] bm;
    bm = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old_v & ~bm) | (new_v & bm);
  endfunction

  task automatic model_step();
    int          best;
    int unsigned bp;
    int          idx;
    logic [31:0] np, ni, rd, w, cid;
    logic        wr;
    best = 0; bp = 0;
    for (int i = 1; i < S; i++) begin
      if (m_pend[i] && m_en[i] && m_prio[i] != 0 && (best == 0 || m_prio[i] > bp)) begin
        best = i; bp = m_prio[i];
      end
    end
    np = m_pend; ni = m_infl; rd = 0;
    for (int i = 1; i < S; i++)
      if (plic_irq[i] && !m_pend[i] && !m_infl[i]) np[i] = 1'b1;
    m_meip = (best != 0) && (bp > m_thr);
    if (plic_valid) begin
      w  = plic_addr & 32'hFFFF_FFFC;
      wr = (plic_wstrb != 0);
      if (w < 32'h80) begin
        idx = int'(w / 4);
        if (idx >= 1 && idx < S) begin
          if (wr) m_prio[idx] = apply_wstrb(m_prio[idx], plic_wdata, plic_wstrb) & PRIO_MASK;
          else    rd = m_prio[idx];
        end
      end else if (w == 32'h80) begin
        if (!wr) rd = m_pend;
      end else if (w == 32'h100) begin
        if (wr) m_en = apply_wstrb(m_en, plic_wdata, plic_wstrb) & SRC_MASK & ~32'h1;
        else    rd = m_en;
      end else if (w == 32'h200) begin
        if (wr) m_thr = apply_wstrb(m_thr, plic_wdata, plic_wstrb) & PRIO_MASK;
        else    rd = m_thr;
      end else if (w == 32'h204) begin
        if (wr) begin
          cid = plic_wdata & 32'h1F;
          if (plic_wstrb[0] && cid >= 1 && cid < S) ni[cid] = 1'b0;
        end else begin
          rd = best;
          if (best != 0) begin np[best] = 1'b0; ni[best] = 1'b1; end
        end
      end
    end
    m_pend = np; m_infl = ni; m_ready = plic_valid; m_rdata = rd;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check("ready", 32'(plic_ready), 32'(m_ready));
    check("rdata", plic_rdata, m_rdata);
    check("meip", 32'(plic_meip), 32'(m_meip));
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    plic_valid = 1'b1; plic_addr = a; plic_wdata = d; plic_wstrb = st;
    tick();
    check("ready_pulse", 32'(plic_ready), 32'h1);
    plic_valid = 1'b0; plic_wstrb = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    bus(a, d, st);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus(a, 32'h0, 4'h0);
    check(tag, plic_rdata, exp);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  st;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(plic_ready), 32'h0);
    check("rst_rdata", plic_rdata, 32'h0);
    check("rst_meip", 32'(plic_meip), 32'h0);
    reset = 1'b0;
    tick();

    // Every mapped offset reads zero after reset.
    for (int i = 0; i < S; i++) rd_chk("rst_prio", 32'(4 * i), 32'h0);
    rd_chk("rst_pend", 32'h080, 32'h0);
    rd_chk("rst_en", 32'h100, 32'h0);
    rd_chk("rst_thr", 32'h200, 32'h0);
    rd_chk("rst_claim", 32'h204, 32'h0);
    tick();
    check("rst_ready_once", 32'(plic_ready), 32'h0);

    // Single source: pulse, claim, complete.
    wr(32'h00C, 32'd2, 4'hF); wr(32'h100, 32'h08, 4'hF); wr(32'h200, 32'd0, 4'hF);
    plic_irq[3] = 1'b1; tick(); plic_irq[3] = 1'b0;
    rd_chk("s2_pend", 32'h080, 32'h08);
    check("s2_meip_on", 32'(plic_meip), 32'h1);
    rd_chk("s2_claim", 32'h204, 32'd3);
    rd_chk("s2_pend_clr", 32'h080, 32'h0);
    check("s2_meip_off", 32'(plic_meip), 32'h0);
    wr(32'h204, 32'd3, 4'h1);
    tick(); tick();
    rd_chk("s2_no_repend", 32'h080, 32'h0);
    plic_irq[3] = 1'b1; tick(); plic_irq[3] = 1'b0;
    rd_chk("s2_inflight_clr", 32'h080, 32'h08);
    rd_chk("s2_claim_again", 32'h204, 32'd3);
    wr(32'h204, 32'd3, 4'h1);

    // Priority order with a tie going to the lower id.
    wr(32'h008, 32'd5, 4'hF); wr(32'h014, 32'd5, 4'hF); wr(32'h018, 32'd4, 4'hF);
    wr(32'h100, 32'h64, 4'hF);
    plic_irq = S'(32'h64); tick();
    rd_chk("s3_claim_a", 32'h204, 32'd2);
    rd_chk("s3_claim_b", 32'h204, 32'd5);
    rd_chk("s3_claim_c", 32'h204, 32'd6);
    rd_chk("s3_claim_none", 32'h204, 32'd0);
    repeat (3) tick();
    rd_chk("s3_held_no_repend", 32'h080, 32'h0);
    plic_irq = '0;
    wr(32'h204, 32'd2, 4'h1); wr(32'h204, 32'd5, 4'h1); wr(32'h204, 32'd6, 4'h1);
    rd_chk("s3_done", 32'h080, 32'h0);

    // Threshold masks meip but not claim.
    wr(32'h200, 32'd5, 4'hF); wr(32'h010, 32'd5, 4'hF); wr(32'h100, 32'h10, 4'hF);
    plic_irq[4] = 1'b1; tick(); plic_irq[4] = 1'b0;
    rd_chk("s4_pend", 32'h080, 32'h10);
    tick();
    check("s4_meip_masked", 32'(plic_meip), 32'h0);
    rd_chk("s4_claim", 32'h204, 32'd4);
    wr(32'h204, 32'd4, 4'h1);
    plic_irq[4] = 1'b1; tick(); plic_irq[4] = 1'b0;
    tick();
    check("s4_meip_still_masked", 32'(plic_meip), 32'h0);
    wr(32'h200, 32'd4, 4'hF);
    tick();
    check("s4_meip_thr_lowered", 32'(plic_meip), 32'h1);
    rd_chk("s4_claim2", 32'h204, 32'd4);
    wr(32'h204, 32'd4, 4'h1);

    // Held level re-pends one edge after complete; pending is read-only.
    wr(32'h200, 32'd0, 4'hF); wr(32'h004, 32'd1, 4'hF); wr(32'h100, 32'h02, 4'hF);
    plic_irq[1] = 1'b1; tick();
    rd_chk("s5_claim", 32'h204, 32'd1);
    wr(32'h204, 32'd1, 4'h1);
    rd_chk("s5_pend_pre", 32'h080, 32'h0);
    check("s5_meip_pre", 32'(plic_meip), 32'h0);
    rd_chk("s5_pend_re", 32'h080, 32'h02);
    check("s5_meip_re", 32'(plic_meip), 32'h1);
    wr(32'h080, 32'h0, 4'hF);
    rd_chk("s5_pend_ro", 32'h080, 32'h02);
    rd_chk("s5_claim2", 32'h204, 32'd1);
    plic_irq[1] = 1'b0;
    wr(32'h204, 32'd1, 4'h1);

    // Reset while a claim read is outstanding.
    wr(32'h00C, 32'd3, 4'hF); wr(32'h100, 32'h08, 4'hF);
    plic_irq[3] = 1'b1; tick(); plic_irq[3] = 1'b0;
    plic_valid = 1'b1; plic_addr = 32'h204; plic_wstrb = 4'h0;
    @(posedge clock);
    #1 reset = 1'b1;
    plic_valid = 1'b0;
    @(negedge clock);
    check("s6_ready_dropped", 32'(plic_ready), 32'h0);
    check("s6_rdata_zero", plic_rdata, 32'h0);
    check("s6_meip_zero", 32'(plic_meip), 32'h0);
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    check("s6_no_late_ready", 32'(plic_ready), 32'h0);
    rd_chk("s6_prio3", 32'h00C, 32'h0);
    rd_chk("s6_en", 32'h100, 32'h0);
    rd_chk("s6_pend", 32'h080, 32'h0);
    rd_chk("s6_unmapped", 32'h300, 32'h0);
    wr(32'h300, 32'hFFFF_FFFF, 4'hF);
    wr(32'h204, 32'd0, 4'hF);
    wr(32'h000, 32'd7, 4'hF);
    wr(32'h020, 32'd7, 4'hF);
    rd_chk("s6_prio0", 32'h000, 32'h0);
    rd_chk("s6_prio_oob", 32'h020, 32'h0);
    rd_chk("s6_thr", 32'h200, 32'h0);
    wr(32'h00F, 32'd6, 4'hF);
    rd_chk("s6_addr_lsb_ignored", 32'h00C, 32'd6);
    wr(32'h100, 32'h0000_FF00, 4'h2);
    rd_chk("s6_en_hi_byte", 32'h100, 32'h0);
    wr(32'h100, 32'h0000_00FF, 4'h1);
    rd_chk("s6_en_bit0", 32'h100, 32'hFE);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      plic_irq   = S'($urandom & $urandom);
      plic_instr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 14))
          0, 1, 2, 3, 4, 5, 6, 7, 8: a = 32'(4 * $urandom_range(0, 8));
          9:       a = 32'h080;
          10:      a = 32'h100;
          11:      a = 32'h200;
          12, 13:  a = 32'h204;
          default: a = 32'h300;
        endcase
        a  = a | 32'($urandom_range(0, 3));
        d  = $urandom;
        if ((a & 32'hFFFF_FFFC) == 32'h204) d[4:0] = 5'($urandom_range(0, 9));
        st = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        bus(a, d, st);
      end else begin
        tick();
      end
    end
    plic_irq = '0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
